reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 'd100000, SHALL be the maximum number of clock cycles wr_req waits for wr_ack (2 ms at 50 MHz).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, in this order:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous reset, active low.
- mb_wen  input  1  single-cycle write request from func_hander (its reg_wen).
- mb_wdat  input  16  Modbus write data; sampled with mb_wen.
- mb_w_done  output  1  single-cycle completion pulse to func_hander (its reg_w_done).
- mb_w_status  output  1  1 = write succeeded; valid only while mb_w_done=1 (its reg_w_status).
- loc_wen  input  1  single-cycle write request from the local host.
- loc_wdat  input  16  local write data; sampled with loc_wen.
- loc_w_done  output  1  single-cycle completion pulse to the local host.
- loc_w_status  output  1  1 = success; valid only while loc_w_done=1.
- wr_req  output  1  level request to the shared register port; held until ack or timeout.
- wr_data  output  16  data to the register port; stable while wr_req=1.
- wr_ack  input  1  register port accepted the write.
- wr_err  input  1  register port rejected the write; sampled only when wr_ack=1.
- busy  output  1  1 in any state other than IDLE.
- timeout_flag  output  1  sticky; set on any timeout.
- drop_flag  output  1  sticky; set when a request is discarded.

Function
REQ-004 Each requester SHALL have a pending flag and a 16-bit data latch, both loaded on the clock edge that samples its wen=1.
REQ-005 A wen arriving while that requester is pending or in service SHALL be discarded and SHALL set drop_flag; the held data SHALL be unchanged.
REQ-006 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-007 In IDLE with at least one pending flag set, the FSM SHALL:
- grant one requester;
- clear its pending flag;
- set wr_req=1 and wr_data to the granted latch;
- enter ISSUE.
REQ-008 Latency: wr_req SHALL be 1 in the second cycle after the cycle in which wen=1 is sampled.
REQ-009 When both requesters are pending, the grant SHALL go to the requester not granted last (round-robin); last_grant SHALL reset to local, so Modbus wins the first tie.
REQ-010 When one requester is pending alone, it SHALL be granted regardless of last_grant.
REQ-011 In ISSUE, a 17-bit cycle counter SHALL start at 0 and increment once per cycle.
REQ-012 In ISSUE with wr_ack=1:
- wr_req SHALL drop at the next edge;
- the granted requester's done SHALL pulse for one cycle, with status = !wr_err;
- the FSM SHALL enter RESP.
REQ-013 In ISSUE with wr_ack=0 and counter = TIMEOUT_CYCLES-1:
- wr_req SHALL drop at the next edge;
- done SHALL pulse with status=0;
- timeout_flag SHALL be set;
- the FSM SHALL enter RESP.
REQ-014 If wr_ack=1 in the timeout cycle, the ack SHALL win and timeout_flag SHALL stay unchanged.
REQ-015 RESP SHALL last exactly one cycle and then return to IDLE; no grant SHALL be made in RESP.
REQ-016 A new wen from the non-granted requester SHALL be accepted in any state.
REQ-017 At most one done output SHALL be 1 in any cycle.
REQ-018 wr_ack arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-019 While rst_n_in=0, asynchronously:
- state SHALL be IDLE;
- wr_req, all done and status outputs, busy, timeout_flag and drop_flag SHALL be 0;
- wr_data, both latches and the counter SHALL be 0x0000;
- both pending flags SHALL be 0 and last_grant SHALL be local.
REQ-020 Reset during ISSUE SHALL drop wr_req immediately and SHALL produce no done pulse.

Structure
REQ-021 A shared package SHALL hold the state encodings (IDLE/ISSUE/RESP), the requester IDs (MB=0, LOC=1) and the default timeout constant.
REQ-022 The block SHALL be a single module with no sub-module; arbitration state is the pending flags plus last_grant.

Verification (bench with TIMEOUT_CYCLES='d64)
REQ-023 mb_wen with 0x0005; wr_ack=1 and wr_err=0 three cycles after wr_req -> wr_data=0x0005, mb_w_done pulses with mb_w_status=1, and mb_wen-to-wr_req latency is 2 cycles.
REQ-024 mb_wen and loc_wen in the same cycle (0x0003, 0xAAAA), each acked -> Modbus is served first (0x0003), then local (0xAAAA); a second tie is granted to Modbus again.
REQ-025 loc_wen with 0x1234 and wr_ack never asserted -> wr_req is high for exactly 64 cycles, loc_w_done pulses with status=0, and timeout_flag=1.
REQ-026 mb_wen with 0x0007, then ack with wr_err=1 -> mb_w_status=0 and timeout_flag=0.
REQ-027 A second mb_wen (0x0009) during ISSUE of 0x0007 -> drop_flag=1 and only one wr_req cycle occurs, with data 0x0007.
REQ-028 rst_n_in pulsed low mid-ISSUE -> wr_req=0 asynchronously, no done pulse, and a subsequent mb_wen is served normally.

Source files
------------

// File: rtl/reg_wr_arbiter_pkg.sv
// Shared types and constants for the two-master register write arbiter.
package reg_wr_arbiter_pkg;

   localparam int unsigned DATA_W          = 16;
   localparam int unsigned CNT_W           = 17;
   localparam int unsigned TIMEOUT_DEFAULT = 100000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   typedef enum logic {
      REQ_MB  = 1'b0,
      REQ_LOC = 1'b1
   } req_id_e;

   // Round-robin on a tie, otherwise whichever requester is pending.
   function automatic req_id_e pick_grant(input logic    mb_pend,
                                          input logic    loc_pend,
                                          input req_id_e last_grant);
      if (mb_pend && loc_pend) begin
         return (last_grant == REQ_MB) ? REQ_LOC : REQ_MB;
      end
      return mb_pend ? REQ_MB : REQ_LOC;
   endfunction

endpackage

// File: rtl/reg_wr_arbiter.sv
// Arbitrates Modbus and local-host single-cycle write requests onto one
// handshaked register write port, with ack timeout and drop detection.
module reg_wr_arbiter
   import reg_wr_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              mb_wen,
   input  logic [DATA_W-1:0] mb_wdat,
   output logic              mb_w_done,
   output logic              mb_w_status,
   input  logic              loc_wen,
   input  logic [DATA_W-1:0] loc_wdat,
   output logic              loc_w_done,
   output logic              loc_w_status,
   output logic              wr_req,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ack,
   input  logic              wr_err,
   output logic              busy,
   output logic              timeout_flag,
   output logic              drop_flag
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   req_id_e           grant_q, grant_d;
   req_id_e           last_q, last_d;
   req_id_e           gnt_c;
   logic              mb_pend_q, mb_pend_d;
   logic              loc_pend_q, loc_pend_d;
   logic [DATA_W-1:0] mb_lat_q, mb_lat_d;
   logic [DATA_W-1:0] loc_lat_q, loc_lat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_req_q, wr_req_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              mb_done_q, mb_done_d;
   logic              mb_status_q, mb_status_d;
   logic              loc_done_q, loc_done_d;
   logic              loc_status_q, loc_status_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic              drop_q, drop_d;
   logic              mb_in_svc_c, loc_in_svc_c;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      mb_pend_d    = mb_pend_q;
      loc_pend_d   = loc_pend_q;
      mb_lat_d     = mb_lat_q;
      loc_lat_d    = loc_lat_q;
      cnt_d        = cnt_q;
      wr_req_d     = wr_req_q;
      wr_data_d    = wr_data_q;
      mb_done_d    = 1'b0;
      mb_status_d  = 1'b0;
      loc_done_d   = 1'b0;
      loc_status_d = 1'b0;
      timeout_d    = timeout_q;
      drop_d       = drop_q;
      gnt_c        = pick_grant(mb_pend_q, loc_pend_q, last_q);
      mb_in_svc_c  = (state_q == ST_ISSUE) && (grant_q == REQ_MB);
      loc_in_svc_c = (state_q == ST_ISSUE) && (grant_q == REQ_LOC);

      // Intake: a requester already holding a slot loses its new write
      if (mb_wen) begin
         if (mb_pend_q || mb_in_svc_c) begin
            drop_d = 1'b1;
         end else begin
            mb_pend_d = 1'b1;
            mb_lat_d  = mb_wdat;
         end
      end
      if (loc_wen) begin
         if (loc_pend_q || loc_in_svc_c) begin
            drop_d = 1'b1;
         end else begin
            loc_pend_d = 1'b1;
            loc_lat_d  = loc_wdat;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (mb_pend_q || loc_pend_q) begin
               grant_d  = gnt_c;
               last_d   = gnt_c;
               wr_req_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_ISSUE;
               if (gnt_c == REQ_MB) begin
                  mb_pend_d = 1'b0;
                  wr_data_d = mb_lat_q;
               end else begin
                  loc_pend_d = 1'b0;
                  wr_data_d  = loc_lat_q;
               end
            end
         end
         ST_ISSUE: begin
            // Ack takes priority over a timeout landing in the same cycle
            if (wr_ack) begin
               wr_req_d = 1'b0;
               state_d  = ST_RESP;
               if (grant_q == REQ_MB) begin
                  mb_done_d   = 1'b1;
                  mb_status_d = ~wr_err;
               end else begin
                  loc_done_d   = 1'b1;
                  loc_status_d = ~wr_err;
               end
            end else if (cnt_q == CNT_LAST) begin
               wr_req_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_RESP;
               if (grant_q == REQ_MB) begin
                  mb_done_d = 1'b1;
               end else begin
                  loc_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ST_IDLE;
         grant_q      <= REQ_LOC;
         last_q       <= REQ_LOC;
         mb_pend_q    <= 1'b0;
         loc_pend_q   <= 1'b0;
         mb_lat_q     <= '0;
         loc_lat_q    <= '0;
         cnt_q        <= '0;
         wr_req_q     <= 1'b0;
         wr_data_q    <= '0;
         mb_done_q    <= 1'b0;
         mb_status_q  <= 1'b0;
         loc_done_q   <= 1'b0;
         loc_status_q <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         mb_pend_q    <= mb_pend_d;
         loc_pend_q   <= loc_pend_d;
         mb_lat_q     <= mb_lat_d;
         loc_lat_q    <= loc_lat_d;
         cnt_q        <= cnt_d;
         wr_req_q     <= wr_req_d;
         wr_data_q    <= wr_data_d;
         mb_done_q    <= mb_done_d;
         mb_status_q  <= mb_status_d;
         loc_done_q   <= loc_done_d;
         loc_status_q <= loc_status_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
         drop_q       <= drop_d;
      end
   end

   assign mb_w_done    = mb_done_q;
   assign mb_w_status  = mb_status_q;
   assign loc_w_done   = loc_done_q;
   assign loc_w_status = loc_status_q;
   assign wr_req       = wr_req_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign timeout_flag = timeout_q;
   assign drop_flag    = drop_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench: a transaction-timeline model predicts every grant and
// completion; an independent monitor checks the DUT against those predictions.
module tb_reg_wr_arbiter;
   import reg_wr_arbiter_pkg::*;

   localparam int unsigned TO = 64;

   logic        clk_in, rst_n_in;
   logic        mb_wen, loc_wen, wr_ack, wr_err;
   logic [15:0] mb_wdat, loc_wdat;
   logic        mb_w_done, mb_w_status, loc_w_done, loc_w_status;
   logic        wr_req, busy, timeout_flag, drop_flag;
   logic [15:0] wr_data;

   reg_wr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .mb_wen(mb_wen), .mb_wdat(mb_wdat),
      .mb_w_done(mb_w_done), .mb_w_status(mb_w_status),
      .loc_wen(loc_wen), .loc_wdat(loc_wdat),
      .loc_w_done(loc_w_done), .loc_w_status(loc_w_status),
      .wr_req(wr_req), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .busy(busy), .timeout_flag(timeout_flag), .drop_flag(drop_flag)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      int          id;
      logic [15:0] data;
      bit          status;
      int          len;
      int          rise;
      int          done;
      bit          to;
   } exp_t;

   exp_t exp_q[$];
   int   plan_d[$];
   bit   plan_e[$];
   int   n_checks, n_fail;
   int   cyc, n_grant, n_rise;
   bit   noise_en;

   // Model state: pending slots plus the service window of the last grant
   bit          m_pend[2];
   logic [15:0] m_data[2];
   int          m_prev, m_gnt, m_first, m_lastc;
   bit          m_drop, m_to;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int get_d(input int i);
      if (i < plan_d.size()) return plan_d[i];
      return 2;
   endfunction

   function automatic bit get_e(input int i);
      if (i < plan_e.size()) return plan_e[i];
      return 1'b0;
   endfunction

   task automatic plan(input int d, input bit e);
      plan_d.push_back(d);
      plan_e.push_back(e);
   endtask

   // Reference model: decides grants and computes the full timeline of each one
   initial begin : model
      int   c, r, d, k;
      bit   e, tmo, arr_mb, arr_loc;
      exp_t rec;
      cyc = 0; n_grant = 0;
      m_pend = '{1'b0, 1'b0}; m_data = '{16'h0, 16'h0};
      m_prev = 1; m_gnt = -1; m_first = -10; m_lastc = -10; m_drop = 0; m_to = 0;
      forever begin
         @(posedge clk_in or negedge rst_n_in);
         if (!rst_n_in) begin
            m_pend = '{1'b0, 1'b0}; m_data = '{16'h0, 16'h0};
            m_prev = 1; m_gnt = -1; m_first = -10; m_lastc = -10;
            m_drop = 0; m_to = 0;
            exp_q.delete();
         end else begin
            c = cyc; cyc++;
            arr_mb = 0; arr_loc = 0;
            if (mb_wen) begin
               if (m_pend[0] || (m_gnt == 0 && c >= m_first && c <= m_lastc)) m_drop = 1;
               else arr_mb = 1;
            end
            if (loc_wen) begin
               if (m_pend[1] || (m_gnt == 1 && c >= m_first && c <= m_lastc)) m_drop = 1;
               else arr_loc = 1;
            end
            if (c >= m_lastc + 2 && (m_pend[0] || m_pend[1])) begin
               if (m_pend[0] && m_pend[1]) r = (m_prev == 0) ? 1 : 0;
               else r = m_pend[0] ? 0 : 1;
               m_pend[r] = 0; m_prev = r; m_gnt = r;
               d = get_d(n_grant); e = get_e(n_grant); n_grant++;
               tmo = (d >= int'(TO));
               k = tmo ? int'(TO) : d + 1;
               m_to = m_to | tmo;
               rec.id = r; rec.data = m_data[r]; rec.status = tmo ? 1'b0 : !e;
               rec.len = k; rec.rise = c + 1; rec.done = c + k + 1; rec.to = m_to;
               exp_q.push_back(rec);
               m_first = c + 1; m_lastc = c + k;
            end
            if (arr_mb)  begin m_pend[0] = 1; m_data[0] = mb_wdat;  end
            if (arr_loc) begin m_pend[1] = 1; m_data[1] = loc_wdat; end
         end
      end
   end

   // Register-port responder: acks per plan entry, optional stray acks when idle
   initial begin : responder
      bit r_active;
      int r_cnt, r_idx, n_resp;
      wr_ack = 0; wr_err = 0; r_active = 0; r_cnt = 0; r_idx = 0; n_resp = 0;
      forever begin
         @(negedge clk_in);
         wr_ack = 0; wr_err = 0;
         if (wr_req) begin
            if (!r_active) begin
               r_active = 1; r_cnt = 0; r_idx = n_resp; n_resp++;
            end else begin
               r_cnt++;
            end
            if (r_cnt == get_d(r_idx)) begin
               wr_ack = 1; wr_err = get_e(r_idx);
            end
         end else begin
            r_active = 0;
            if (noise_en) begin
               wr_ack = ($urandom % 3 == 0);
               wr_err = 1'($urandom % 2);
            end
         end
      end
   end

   // Monitor: per-cycle window checks and scoreboard pop on each done pulse
   initial begin : monitor
      int          c, rq_len, rq_rise;
      bit          in_req;
      logic [15:0] rq_data;
      exp_t        e;
      in_req = 0; rq_len = 0; rq_rise = 0; rq_data = '0; n_rise = 0;
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            in_req = 0;
         end else begin
            c = cyc;
            chk("wr_req_window", 32'(wr_req), 32'(c >= m_first && c <= m_lastc));
            chk("busy_window", 32'(busy), 32'(c >= m_first && c <= m_lastc + 1));
            chk("drop_flag", 32'(drop_flag), 32'(m_drop));
            chk("one_done", 32'(mb_w_done & loc_w_done), 32'(0));
            if (wr_req) begin
               if (!in_req) begin
                  in_req = 1; rq_data = wr_data; rq_rise = c; rq_len = 0; n_rise++;
               end
               rq_len++;
               chk("wr_data_stable", 32'(wr_data), 32'(rq_data));
            end else begin
               in_req = 0;
            end
            if (mb_w_done || loc_w_done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(mb_w_done | loc_w_done), 32'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("done_id", 32'(loc_w_done), 32'(e.id));
                  chk("done_status", 32'(loc_w_done ? loc_w_status : mb_w_status), 32'(e.status));
                  chk("wr_data", 32'(rq_data), 32'(e.data));
                  chk("req_len", rq_len, e.len);
                  chk("req_rise", rq_rise, e.rise);
                  chk("done_cycle", c, e.done);
                  chk("timeout_flag_at_done", 32'(timeout_flag), 32'(e.to));
               end
            end
         end
      end
   end

   task automatic drive(input bit m, input bit l, input logic [15:0] dm, input logic [15:0] dl);
      mb_wen = m; mb_wdat = dm; loc_wen = l; loc_wdat = dl;
      @(negedge clk_in);
      mb_wen = 0; loc_wen = 0;
   endtask

   task automatic wait_quiet(input int budget);
      int q = 0;
      int n = 0;
      while (q < 3 && n < budget) begin
         @(negedge clk_in);
         n++;
         if (!busy && !wr_req && exp_q.size() == 0 && !m_pend[0] && !m_pend[1]) q++;
         else q = 0;
      end
      chk("quiet_within_budget", 32'(q >= 3), 32'(1));
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!wr_req && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      chk("wr_req_seen", 32'(wr_req), 32'(1));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int r0;
      n_checks = 0; n_fail = 0; noise_en = 0;
      mb_wen = 0; loc_wen = 0; mb_wdat = '0; loc_wdat = '0;
      rst_n_in = 0;
      #1;
      chk("rst_wr_req", 32'(wr_req), 32'(0));
      chk("rst_wr_data", 32'(wr_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_mb_done", 32'(mb_w_done), 32'(0));
      chk("rst_loc_done", 32'(loc_w_done), 32'(0));
      chk("rst_mb_status", 32'(mb_w_status), 32'(0));
      chk("rst_loc_status", 32'(loc_w_status), 32'(0));
      chk("rst_timeout", 32'(timeout_flag), 32'(0));
      chk("rst_drop", 32'(drop_flag), 32'(0));
      repeat (3) @(negedge clk_in);
      rst_n_in = 1;
      @(negedge clk_in);

      // Basic Modbus write, ack three cycles into the request
      plan(3, 0);
      drive(1, 0, 16'h0005, 16'h0);
      chk("latency_cycle1", 32'(wr_req), 32'(0));
      @(negedge clk_in);
      chk("latency_cycle2", 32'(wr_req), 32'(1));
      wait_quiet(200);

      // Two ties: Modbus wins both
      plan(1, 0); plan(1, 0);
      drive(1, 1, 16'h0003, 16'hAAAA);
      wait_quiet(200);
      plan(0, 0); plan(0, 0);
      drive(1, 1, 16'h0011, 16'h0022);
      wait_quiet(200);

      // Register port error
      plan(2, 1);
      drive(1, 0, 16'h0007, 16'h0);
      wait_quiet(200);
      chk("err_timeout_flag", 32'(timeout_flag), 32'(0));
      chk("err_drop_flag", 32'(drop_flag), 32'(0));

      // Second Modbus write while the first is in service
      plan(5, 0);
      r0 = n_rise;
      drive(1, 0, 16'h0007, 16'h0);
      wait_req(10);
      drive(1, 0, 16'h0009, 16'h0);
      wait_quiet(200);
      chk("drop_flag_set", 32'(drop_flag), 32'(1));
      chk("single_issue", n_rise - r0, 32'(1));

      // Ack in the last counted cycle wins over the timeout
      plan(63, 0);
      drive(0, 1, 16'h0, 16'h00F0);
      wait_quiet(300);
      chk("late_ack_no_timeout", 32'(timeout_flag), 32'(0));

      // No ack at all
      plan(1000, 0);
      drive(0, 1, 16'h0, 16'h1234);
      wait_quiet(300);
      chk("timeout_flag_set", 32'(timeout_flag), 32'(1));

      // Reset in the middle of a request, then normal service
      plan(20, 0);
      drive(1, 0, 16'h0BAD, 16'h0);
      wait_req(10);
      @(negedge clk_in);
      @(negedge clk_in);
      #2 rst_n_in = 0;
      #1;
      chk("midrst_wr_req", 32'(wr_req), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_mb_done", 32'(mb_w_done), 32'(0));
      chk("midrst_timeout", 32'(timeout_flag), 32'(0));
      chk("midrst_drop", 32'(drop_flag), 32'(0));
      chk("midrst_wr_data", 32'(wr_data), 32'(0));
      @(negedge clk_in);
      @(negedge clk_in);
      #1 rst_n_in = 1;
      @(negedge clk_in);
      plan(2, 0);
      drive(1, 0, 16'h0C0D, 16'h0);
      wait_quiet(200);

      // Random traffic with stray acks outside requests
      for (int i = 0; i < 200; i++) begin
         int sel;
         sel = int'($urandom % 20);
         if (sel == 0)      plan(1000, 1'($urandom % 2));
         else if (sel == 1) plan(63, 1'($urandom % 2));
         else               plan(int'($urandom % 5), 1'($urandom % 2));
      end
      noise_en = 1;
      repeat (400) begin
         mb_wen   = ($urandom % 5 == 0);
         mb_wdat  = 16'($urandom);
         loc_wen  = ($urandom % 5 == 0);
         loc_wdat = 16'($urandom);
         @(negedge clk_in);
      end
      mb_wen = 0; loc_wen = 0; noise_en = 0;
      wait_quiet(400);

      chk("queue_drained", exp_q.size(), 32'(0));
      chk("issue_count", n_rise, n_grant);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
